// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter and 3-cycle write sequencer for one shared capture register,
// with a write-once lock that rejects all writes until reset.
module shared_reg_arbiter #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8,
   parameter int CNTW  = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ*WIDTH-1:0]   din,
   input  logic                    lock_set,
   output logic [NREQ-1:0]         gnt,
   output logic [NREQ-1:0]         ack,
   output logic                    err,
   output logic [WIDTH-1:0]        q,
   output logic                    locked,
   output logic                    busy,
   output logic [CNTW-1:0]         wr_count
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {IDLE, CAPT, DONE} state_t;

   state_t            state_reg, state_next;
   logic [IW-1:0]     ptr_reg, ptr_next;
   logic [IW-1:0]     winner_reg, winner_next;
   logic [WIDTH-1:0]  data_reg, data_next;
   logic              reject_reg, reject_next;
   logic [WIDTH-1:0]  q_reg, q_next;
   logic              locked_reg;
   logic [CNTW-1:0]   cnt_reg, cnt_next;
   logic [IW-1:0]     pick;
   logic              found;
   logic [WIDTH-1:0]  slice [NREQ];

   // Index arithmetic modulo NREQ, valid for non-power-of-two requester counts.
   function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int k);
      int s;
      s = int'(base) + k;
      if (s >= NREQ) s = s - NREQ;
      return s[IW-1:0];
   endfunction

   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
         assign slice[gi] = din[gi*WIDTH +: WIDTH];
         assign gnt[gi]   = (state_reg == CAPT) && (winner_reg == IW'(gi));
         assign ack[gi]   = (state_reg == DONE) && (winner_reg == IW'(gi));
      end
   endgenerate

   // First set request bit searching upward from ptr_reg, wrapping around.
   always_comb begin
      pick  = ptr_reg;
      found = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         if (!found && req[wrap_add(ptr_reg, k)]) begin
            pick  = wrap_add(ptr_reg, k);
            found = 1'b1;
         end
      end
   end

   always_comb begin
      state_next  = state_reg;
      ptr_next    = ptr_reg;
      winner_next = winner_reg;
      data_next   = data_reg;
      reject_next = reject_reg;
      q_next      = q_reg;
      cnt_next    = cnt_reg;
      case (state_reg)
         IDLE: begin
            if (found) begin
               winner_next = pick;
               data_next   = slice[pick];
               state_next  = CAPT;
            end
         end
         CAPT: begin
            // Lock state at the start of CAPT decides; a same-edge lock_set lands after.
            if (!locked_reg) begin
               q_next      = data_reg;
               cnt_next    = (cnt_reg == '1) ? cnt_reg : cnt_reg + 1'b1;
               reject_next = 1'b0;
            end else begin
               reject_next = 1'b1;
            end
            state_next = DONE;
         end
         DONE: begin
            ptr_next   = wrap_add(winner_reg, 1);
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= IDLE;
         ptr_reg    <= '0;
         winner_reg <= '0;
         data_reg   <= '0;
         reject_reg <= 1'b0;
         q_reg      <= '0;
         locked_reg <= 1'b0;
         cnt_reg    <= '0;
      end else begin
         state_reg  <= state_next;
         ptr_reg    <= ptr_next;
         winner_reg <= winner_next;
         data_reg   <= data_next;
         reject_reg <= reject_next;
         q_reg      <= q_next;
         locked_reg <= locked_reg | lock_set;
         cnt_reg    <= cnt_next;
      end
   end

   assign err      = (state_reg == DONE) && reject_reg;
   assign busy     = (state_reg != IDLE);
   assign q        = q_reg;
   assign locked   = locked_reg;
   assign wr_count = cnt_reg;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Self-checking bench for shared_reg_arbiter: vector table plus hand sequences,
// with a scoreboard queue compared whenever an ack appears.
module tb_shared_reg_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic [31:0] din;
   logic        lock_set;
   logic [3:0]  gnt, ack;
   logic        err, locked, busy;
   logic [7:0]  q, wr_count;

   logic [3:0]  s_gnt, s_ack;
   logic        s_err, s_locked, s_busy;
   logic [7:0]  s_q;
   logic [1:0]  s_wr_count;

   always #5 clk = ~clk;

   shared_reg_arbiter #(.NREQ(4), .WIDTH(8), .CNTW(8)) dut (
      .clk(clk), .rst(rst), .req(req), .din(din), .lock_set(lock_set),
      .gnt(gnt), .ack(ack), .err(err), .q(q), .locked(locked),
      .busy(busy), .wr_count(wr_count)
   );

   shared_reg_arbiter #(.NREQ(4), .WIDTH(8), .CNTW(2)) dut_sat (
      .clk(clk), .rst(rst), .req(req), .din(din), .lock_set(1'b0),
      .gnt(s_gnt), .ack(s_ack), .err(s_err), .q(s_q), .locked(s_locked),
      .busy(s_busy), .wr_count(s_wr_count)
   );

   typedef struct {
      logic [3:0] ack;
      logic       err;
      logic [7:0] q;
      logic [7:0] cnt;
   } sb_t;

   typedef struct {
      logic [3:0]  req;
      logic [31:0] din;
      logic [3:0]  gnt;
      logic        err;
      logic [7:0]  q;
   } vec_t;

   sb_t        sb [$];
   vec_t       vecs [6];
   int         checks = 0;
   int         errors = 0;
   logic       m_lock;
   logic [7:0] m_cnt;
   logic [1:0] sat_exp [5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Scoreboard: every ack pops and compares one expected transaction.
   always @(negedge clk) begin
      sb_t e;
      if (ack !== 4'b0000) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ack: got ack=%b expected no ack", ack);
         end else begin
            e = sb.pop_front();
            chk("ack", {28'd0, ack}, {28'd0, e.ack});
            chk("err", {31'd0, err}, {31'd0, e.err});
            chk("q", {24'd0, q}, {24'd0, e.q});
            chk("wr_count", {24'd0, wr_count}, {24'd0, e.cnt});
            $display("txn ack=%b err=%b q=%h wr_count=%0d", ack, err, q, wr_count);
         end
      end else if (err !== 1'b0) begin
         checks++;
         errors++;
         $display("FAIL err_without_ack: got err=%b expected 0", err);
      end
   end

   task automatic push_exp(input logic [3:0] a, input logic e, input logic [7:0] qv);
      sb_t s;
      if (!e && m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
      s.ack = a; s.err = e; s.q = qv; s.cnt = m_cnt;
      sb.push_back(s);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; req = 4'b0000; lock_set = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      m_lock = 1'b0;
      m_cnt  = 8'd0;
   endtask

   // One full transaction; req is dropped during CAPT to show it cannot cancel.
   task automatic do_txn(input logic [3:0] r, input logic [31:0] d, input logic lock_on_capt,
                         input logic [3:0] exp_gnt, input logic exp_err, input logic [7:0] exp_q);
      @(negedge clk);
      req = r; din = d;
      push_exp(exp_gnt, exp_err, exp_q);
      @(negedge clk);
      chk("gnt", {28'd0, gnt}, {28'd0, exp_gnt});
      chk("busy_capt", {31'd0, busy}, 32'd1);
      req = 4'b0000; din = $urandom;
      if (lock_on_capt) lock_set = 1'b1;
      @(negedge clk);
      lock_set = 1'b0;
      if (lock_on_capt) m_lock = 1'b1;
      @(negedge clk);
      chk("busy_idle", {31'd0, busy}, 32'd0);
      chk("gnt_idle", {28'd0, gnt}, 32'd0);
      chk("locked", {31'd0, locked}, {31'd0, m_lock});
   endtask

   initial begin
      vecs[0] = '{4'b0100, 32'h99A5_8877, 4'b0100, 1'b0, 8'hA5};
      vecs[1] = '{4'b0011, 32'hEEDD_2221, 4'b0001, 1'b0, 8'h21};
      vecs[2] = '{4'b1001, 32'h33CC_BB31, 4'b1000, 1'b0, 8'h33};
      vecs[3] = '{4'b1110, 32'h6655_4144, 4'b0010, 1'b0, 8'h41};
      vecs[4] = '{4'b0010, 32'h0102_5503, 4'b0010, 1'b0, 8'h55};
      vecs[5] = '{4'b0001, 32'hAABB_CCFF, 4'b0001, 1'b0, 8'hFF};
      sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      m_lock = 1'b0;
      m_cnt  = 8'd0;

      // Reset held two cycles with all requests asserted, then released.
      rst = 1'b1; req = 4'b1111; din = 32'hFFFF_FFFF; lock_set = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_q", {24'd0, q}, 32'd0);
         chk("rst_gnt", {28'd0, gnt}, 32'd0);
         chk("rst_ack", {28'd0, ack}, 32'd0);
         chk("rst_locked", {31'd0, locked}, 32'd0);
         chk("rst_wr_count", {24'd0, wr_count}, 32'd0);
         chk("rst_busy", {31'd0, busy}, 32'd0);
         if (i == 1) begin
            rst = 1'b0;
            req = 4'b0000;
         end
      end

      // Vector table: single write then assorted request patterns.
      for (int i = 0; i < 6; i++)
         do_txn(vecs[i].req, vecs[i].din, 1'b0, vecs[i].gnt, vecs[i].err, vecs[i].q);

      // Round-robin with all requests held continuously.
      do_reset();
      @(negedge clk);
      req = 4'b1111; din = 32'h1312_1110;
      push_exp(4'b0001, 1'b0, 8'h10);
      push_exp(4'b0010, 1'b0, 8'h11);
      push_exp(4'b0100, 1'b0, 8'h12);
      push_exp(4'b1000, 1'b0, 8'h13);
      push_exp(4'b0001, 1'b0, 8'h10);
      for (int k = 0; k < 5; k++) begin
         logic [3:0] eg;
         eg = 4'b0001 << (k % 4);
         @(negedge clk);
         chk("rr_gnt", {28'd0, gnt}, {28'd0, eg});
         @(negedge clk);
         if (k == 4) req = 4'b0000;
         @(negedge clk);
         chk("rr_idle_busy", {31'd0, busy}, 32'd0);
      end

      // Lock set on the CAPT edge: that write lands, the next is rejected.
      do_reset();
      do_txn(4'b0100, 32'h0077_0000, 1'b1, 4'b0100, 1'b0, 8'h77);
      do_txn(4'b1000, 32'h8800_0000, 1'b0, 4'b1000, 1'b1, 8'h77);

      // Lock pulsed while idle between two writes.
      do_reset();
      do_txn(4'b0001, 32'h0000_005A, 1'b0, 4'b0001, 1'b0, 8'h5A);
      @(negedge clk);
      lock_set = 1'b1;
      @(negedge clk);
      lock_set = 1'b0;
      m_lock = 1'b1;
      chk("lock_visible", {31'd0, locked}, 32'd1);
      do_txn(4'b0010, 32'h0000_3C00, 1'b0, 4'b0010, 1'b1, 8'h5A);
      repeat (4) @(negedge clk);
      chk("lock_sticky", {31'd0, locked}, 32'd1);

      // Reset during CAPT: no ack, register cleared, pointer back to 0.
      @(negedge clk);
      req = 4'b1000; din = 32'hC300_0000;
      @(negedge clk);
      chk("mid_gnt", {28'd0, gnt}, 32'h8);
      rst = 1'b1; req = 4'b0000;
      @(negedge clk);
      chk("mid_ack", {28'd0, ack}, 32'd0);
      chk("mid_busy", {31'd0, busy}, 32'd0);
      chk("mid_q", {24'd0, q}, 32'd0);
      chk("mid_locked", {31'd0, locked}, 32'd0);
      rst = 1'b0;
      m_lock = 1'b0;
      m_cnt  = 8'd0;
      do_txn(4'b1010, 32'h4433_2211, 1'b0, 4'b0010, 1'b0, 8'h22);

      // Saturation on the 2-bit counter instance.
      do_reset();
      for (int k = 0; k < 5; k++) begin
         do_txn(4'b0001, 32'h0000_0060 + k, 1'b0, 4'b0001, 1'b0, 8'h60 + 8'(k));
         chk("sat_wr_count", {30'd0, s_wr_count}, {30'd0, sat_exp[k]});
      end

      repeat (3) @(negedge clk);
      chk("sb_empty", sb.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
